memory_reader: RTL and testbench

Playback-side memory sequencer. It reads the 62,500-entry sample memory at sequential addresses 0..62499, wrapping to 0, and hands each word to the 1 MHz serializer through a ready/valid handshake. A two-entry prefetch buffer hides memory read latency, so a word is always waiting when the serializer asks. It runs in the 100 MHz system domain and is the read-side counterpart of the capture path that writes the same memory.

---
 rtl/memory_reader.sv | 123 ++++++++++++
 tb/tb_memory_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/memory_reader.sv
// memory_reader: sequential playback reader for the sample memory.
// Walks addresses 0..DEPTH-1 (wrapping) and keeps a two-entry prefetch
// buffer topped up so the serializer always finds a word waiting.
module memory_reader #(
  parameter int DEPTH      = 62500,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              wrap,
  output logic              underrun
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              st, nxt_st;
  // vld_pipe[0] tracks the read on the bus this cycle; vld_pipe[RD_LATENCY]
  // marks the cycle its data is on mem_rdata.
  logic [RD_LATENCY:0] vld_pipe;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [DATA_W-1:0]   tail_q;
  logic [1:0]          cnt;
  logic [3:0]          inflight, occ;
  logic                issue, push, pop;

  assign push      = vld_pipe[RD_LATENCY];
  assign ser_valid = (cnt != 2'd0);
  assign pop       = ser_ready & ser_valid;
  // st is FETCH exactly in the cycle a registered read is on the bus
  assign mem_rd_en = (st == S_FETCH);

  // Occupancy = buffered words + reads still in the pipeline (pre-pop)
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) inflight = inflight + 4'(vld_pipe[i]);
    occ = inflight + {2'b00, cnt};
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= S_IDLE;
    else        st <= nxt_st;
  end

  // Next state: re-derived every cycle from enable and occupancy
  always_comb begin
    nxt_st = S_IDLE;
    if (!restart && enable) nxt_st = (occ < 4'd2) ? S_FETCH : S_FULL;
  end

  // Output decode: a read is issued whenever we are heading into FETCH
  always_comb begin
    issue = (nxt_st == S_FETCH);
  end

  // Address generation and wrap pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nxt_addr    <= '0;
      mem_address <= '0;
      wrap        <= 1'b0;
    end else if (restart) begin
      nxt_addr <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= issue && (nxt_addr == LAST_ADDR);
      if (issue) begin
        mem_address <= nxt_addr;
        nxt_addr    <= (nxt_addr == LAST_ADDR) ? '0 : nxt_addr + 1'b1;
      end
    end
  end

  // In-flight valid shift pipeline; restart discards everything in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        vld_pipe <= '0;
    else if (restart)  vld_pipe <= '0;
    else               vld_pipe <= {vld_pipe[RD_LATENCY-1:0], issue};
  end

  // Two-entry FIFO: ser_data is the registered head so it holds when empty
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      ser_data <= '0;
      tail_q   <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (push && pop) begin
      if (cnt == 2'd1) ser_data <= mem_rdata;
      else begin
        ser_data <= tail_q;
        tail_q   <= mem_rdata;
      end
    end else if (push) begin
      if (cnt == 2'd0) ser_data <= mem_rdata;
      else             tail_q   <= mem_rdata;
      cnt <= cnt + 2'd1;
    end else if (pop) begin
      if (cnt == 2'd2) ser_data <= tail_q;
      cnt <= cnt - 2'd1;
    end
  end

  // Sticky underrun: serializer asked while nothing was waiting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) underrun <= 1'b0;
    else        underrun <= underrun | (ser_ready & ~ser_valid);
  end

endmodule

// File: tb/tb_memory_reader.sv
// Bench for memory_reader: directed phases plus random traffic, with a
// scoreboard that predicts the popped word sequence and issue addresses.
module tb_memory_reader;
  localparam int DEPTH = 500;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int L     = 2;

  logic          clock = 1'b0, reset = 1'b0, enable = 1'b0, restart = 1'b0, ser_ready = 1'b0;
  logic [AW-1:0] mem_address;
  logic          mem_rd_en, ser_valid, wrap, underrun;
  logic [DW-1:0] mem_rdata, ser_data;
  logic [DW-1:0] rd_pipe [L];

  int checks = 0, errors = 0;

  memory_reader #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .enable(enable), .restart(restart),
    .mem_address(mem_address), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .wrap(wrap), .underrun(underrun));

  always #5 clock = ~clock;

  function automatic logic [15:0] word(input int a);
    return 16'(a * 40503 + 12345);
  endfunction

  // Memory model: data appears L cycles after the read-enable cycle
  always @(posedge clock) begin
    rd_pipe[0] <= mem_rd_en ? word(int'(mem_address)) : 16'hDEAD;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[L-1];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard / reference model
  logic [15:0] exp_q [$];
  int fill_addr = 0, iss_addr = 0, wraps = 0;
  logic exp_und = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      fill_addr = 0; iss_addr = 0; exp_und = 1'b0; wraps = 0;
    end else begin
      chk("underrun", underrun, exp_und);
      if (mem_rd_en) begin
        chk("rd_addr", mem_address, iss_addr);
        chk("wrap", wrap, iss_addr == DEPTH - 1);
        if (wrap) wraps++;
        iss_addr = (iss_addr + 1) % DEPTH;
      end else begin
        chk("wrap_idle", wrap, 1'b0);
      end
      if (ser_ready) begin
        if (!ser_valid) exp_und = 1'b1;
        else if (!restart) begin
          while (exp_q.size() < 2) begin
            exp_q.push_back(word(fill_addr));
            fill_addr = (fill_addr + 1) % DEPTH;
          end
          chk("ser_data", ser_data, exp_q.pop_front());
        end
      end
      if (restart) begin
        exp_q.delete();
        fill_addr = 0; iss_addr = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pop_one(input int gap);
    ser_ready = 1'b1; cyc(1); ser_ready = 1'b0; cyc(gap);
  endtask

  initial begin
    // Run briefly, then hit reset mid-operation
    cyc(2); reset = 1'b1; enable = 1'b1;
    cyc(8); pop_one(3);
    #3 reset = 1'b0; #1;
    chk("rst_addr", mem_address, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_ser_data", ser_data, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_underrun", underrun, 0);
    enable = 1'b0;
    cyc(2); reset = 1'b1; cyc(2);

    // Startup timing: reads in cycles 1 and 2, data valid in cycle 4
    enable = 1'b1;
    cyc(1); chk("start_rd0", mem_rd_en, 1); chk("start_addr0", mem_address, 0);
    cyc(1); chk("start_rd1", mem_rd_en, 1); chk("start_addr1", mem_address, 1);
    cyc(1); chk("start_full", mem_rd_en, 0); chk("start_nvalid", ser_valid, 0);
    cyc(1); chk("start_valid", ser_valid, 1); chk("start_data", ser_data, word(0));

    // Steady streaming, then continue well past the wrap point
    for (int i = 0; i < 200; i++) pop_one($urandom_range(6, 20));
    chk("stream_no_underrun", underrun, 0);
    for (int i = 0; i < 400; i++) pop_one($urandom_range(6, 9));
    chk("wrap_count", wraps, 1);

    // Restart together with ser_ready on a full buffer
    chk("pre_restart_valid", ser_valid, 1);
    restart = 1'b1; ser_ready = 1'b1; cyc(1);
    restart = 1'b0; ser_ready = 1'b0;
    chk("restart_empty", ser_valid, 0);
    chk("restart_no_rd", mem_rd_en, 0);
    cyc(1); chk("restart_rd", mem_rd_en, 1); chk("restart_addr0", mem_address, 0);
    cyc(8);

    // Enable gating: two reads in flight when enable drops
    enable = 1'b0; restart = 1'b1; cyc(1);
    restart = 1'b0; enable = 1'b1; cyc(2);
    enable = 1'b0; cyc(10);
    chk("gate_valid0", ser_valid, 1);
    pop_one(3); chk("gate_valid1", ser_valid, 1);
    pop_one(3); chk("gate_empty", ser_valid, 0);

    // Underrun while empty, then resume fetching at address 2
    pop_one(1); chk("underrun_set", underrun, 1);
    enable = 1'b1; cyc(12);
    pop_one(6); pop_one(6);
    chk("underrun_sticky", underrun, 1);

    // Random traffic: back-to-back pops, enable toggles, occasional restart
    for (int i = 0; i < 3000; i++) begin
      ser_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      restart = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    ser_ready = 1'b0; restart = 1'b0; enable = 1'b1;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
